// File: rtl/alu_result_queue.sv
// alu_result_queue: DEPTH-entry circular queue for ALU results.
// Captures results on the falling edge of clk and presents them in order
// through a valid/ready handshake, so the ALU can run ahead of a stalled
// consumer.
// Optional feature macro: ALU_OUT_ZERO_FLAG_EN adds a per-entry "result was
// zero" bit and the out_zero port.
module alu_result_queue #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] result,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] ALUOut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count
`ifdef ALU_OUT_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_nxt;
  logic [PW-1:0]    w_rd_nxt;

  // Status comes straight from the registered count, so it only moves at
  // falling edges or on reset. A full queue refuses a push even when a pop
  // happens at the same edge (no pass-through).
  assign w_in_ready  = (r_count != FULL);
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid  && w_in_ready;
  assign w_pop       = out_ready && w_out_valid;

  // Explicit wrap compare: DEPTH need not be a power of two.
  assign w_wr_nxt = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_nxt = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PW'(1);

  // Entry storage: write the result at the write pointer; a flush drops it.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= result;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop at the same edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_count;
  // Head read is purely from storage; result never reaches ALUOut directly.
  assign ALUOut    = w_out_valid ? r_mem[r_rd_ptr] : '0;

`ifdef ALU_OUT_ZERO_FLAG_EN
  logic r_zf [DEPTH];

  // Zero flag captured alongside each entry so the branch unit skips a compare.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_zf[i] <= 1'b0;
    end else if (w_push && !flush) begin
      r_zf[r_wr_ptr] <= (result == '0);
    end
  end

  assign out_zero = w_out_valid & r_zf[r_rd_ptr];
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Bench for alu_result_queue: queue-based reference model, per-cycle compare
// process, and directed vectors with literal expectations (DEPTH=4 and DEPTH=3).
module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // DEPTH = 4 instance signals
  logic [31:0] res4 = '0;
  logic        v4 = 0, f4 = 0, ordy4 = 0;
  logic        in_ready4, out_valid4;
  logic [31:0] aluout4;
  logic [2:0]  count4;
  // DEPTH = 3 instance signals
  logic [31:0] res3 = '0;
  logic        v3 = 0, f3 = 0, ordy3 = 0;
  logic        in_ready3, out_valid3;
  logic [31:0] aluout3;
  logic [1:0]  count3;
`ifdef ALU_OUT_ZERO_FLAG_EN
  logic        oz4, oz3;
`endif

  alu_result_queue #(.WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .result(res4), .in_valid(v4), .in_ready(in_ready4),
    .flush(f4), .ALUOut(aluout4), .out_valid(out_valid4), .out_ready(ordy4),
    .count(count4)
`ifdef ALU_OUT_ZERO_FLAG_EN
    , .out_zero(oz4)
`endif
  );

  alu_result_queue #(.WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .result(res3), .in_valid(v3), .in_ready(in_ready3),
    .flush(f3), .ALUOut(aluout3), .out_valid(out_valid3), .out_ready(ordy3),
    .count(count3)
`ifdef ALU_OUT_ZERO_FLAG_EN
    , .out_zero(oz3)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: an ordered list of stored results per instance.
  logic [31:0] q4[$];
  logic [31:0] q3[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q4.delete();
      q3.delete();
    end else begin
      if (f4) q4.delete();
      else begin
        automatic bit push = v4 && (q4.size() < 4);
        automatic bit pop  = ordy4 && (q4.size() > 0);
        if (pop)  void'(q4.pop_front());
        if (push) q4.push_back(res4);
      end
      if (f3) q3.delete();
      else begin
        automatic bit push = v3 && (q3.size() < 3);
        automatic bit pop  = ordy3 && (q3.size() > 0);
        if (pop)  void'(q3.pop_front());
        if (push) q3.push_back(res3);
      end
    end
  end

  // Compare every rising edge (outputs settle at falling edges).
  always @(posedge clk) begin
    if (rst_n) begin
      chk("m4_count",     count4,     q4.size());
      chk("m4_in_ready",  in_ready4,  q4.size() != 4);
      chk("m4_out_valid", out_valid4, q4.size() != 0);
      chk("m4_aluout",    aluout4,    (q4.size() != 0) ? q4[0] : 32'h0);
      chk("m3_count",     count3,     q3.size());
      chk("m3_in_ready",  in_ready3,  q3.size() != 3);
      chk("m3_out_valid", out_valid3, q3.size() != 0);
      chk("m3_aluout",    aluout3,    (q3.size() != 0) ? q3[0] : 32'h0);
`ifdef ALU_OUT_ZERO_FLAG_EN
      chk("m4_out_zero",  oz4, (q4.size() != 0) && (q4[0] == 0));
      chk("m3_out_zero",  oz3, (q3.size() != 0) && (q3[0] == 0));
`endif
    end
  end

  // One falling edge on the DEPTH=4 instance; returns just after the edge.
  task automatic t4(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    v4 = v; res4 = d; ordy4 = ordy; f4 = fl;
    @(negedge clk); #1;
    v4 = 0; ordy4 = 0; f4 = 0;
  endtask

  task automatic t3(input logic v, input logic [31:0] d, input logic ordy);
    v3 = v; res3 = d; ordy3 = ordy;
    @(negedge clk); #1;
    v3 = 0; ordy3 = 0;
  endtask

  logic [31:0] vals [4];
  logic [31:0] prev, nv;

  initial begin
    // Reset state
    #2;
    chk("rst_count", count4, 0);
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_in_ready", in_ready4, 1);
    chk("rst_aluout", aluout4, 0);
    @(posedge clk); #1 rst_n = 1;

    // Fill and drain
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    t4(1, vals[0], 0, 0);
    chk("first_push_head", aluout4, 32'h11);
    chk("first_push_valid", out_valid4, 1);
    for (int i = 1; i < 4; i++) t4(1, vals[i], 0, 0);
    chk("fill_count", count4, 4);
    chk("fill_in_ready", in_ready4, 0);
    t4(1, 32'h55, 0, 0);
    chk("fifth_push_count", count4, 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", aluout4, vals[i]);
      t4(0, 0, 1, 0);
    end
    chk("drained_valid", out_valid4, 0);
    chk("drained_aluout", aluout4, 0);

    // Full queue: push and pop together, push blocked
    for (int i = 0; i < 4; i++) t4(1, 32'hA1 + i, 0, 0);
    t4(1, 32'h99, 1, 0);
    chk("full_pp_count", count4, 3);
    chk("full_pp_head", aluout4, 32'hA2);
    for (int i = 0; i < 3; i++) begin
      chk("full_pp_drain", aluout4, 32'hA2 + i);
      t4(0, 0, 1, 0);
    end
    chk("full_pp_no99", out_valid4, 0);

    // Empty queue: push and pop together, push completes
    t4(1, 32'h7, 1, 0);
    chk("empty_pp_count", count4, 1);
    chk("empty_pp_head", aluout4, 32'h7);
    t4(0, 0, 1, 0);

    // Flush priority over push
    t4(1, 32'h1, 0, 0);
    t4(1, 32'h2, 0, 0);
    chk("pre_flush_count", count4, 2);
    t4(1, 32'hAB, 0, 1);
    chk("flush_count", count4, 0);
    chk("flush_valid", out_valid4, 0);
    t4(1, 32'hCD, 0, 0);
    chk("post_flush_head", aluout4, 32'hCD);
    chk("post_flush_count", count4, 1);
    t4(0, 0, 1, 0);

`ifdef ALU_OUT_ZERO_FLAG_EN
    t4(1, 32'h0, 0, 0);
    t4(1, 32'h5, 0, 0);
    chk("zflag_set", oz4, 1);
    t4(0, 0, 1, 0);
    chk("zflag_clear", oz4, 0);
    t4(0, 0, 1, 0);
`endif

    // Wrap-around on DEPTH=3: steady push/pop keeps count at 1
    prev = 32'hC0DE0000;
    t3(1, prev, 0);
    for (int i = 0; i < 10; i++) begin
      nv = $urandom;
      chk("wrap_head", aluout3, prev);
      t3(1, nv, 1);
      chk("wrap_count", count3, 1);
      prev = nv;
    end
    chk("wrap_last", aluout3, prev);
    t3(0, 0, 1);
    chk("wrap_empty", out_valid3, 0);

    // Reset mid-stream with three entries
    for (int i = 0; i < 3; i++) t4(1, 32'h60 + i, 0, 0);
    chk("pre_rst_count", count4, 3);
    #1 rst_n = 0;
    #1;
    chk("midrst_count", count4, 0);
    chk("midrst_valid", out_valid4, 0);
    chk("midrst_aluout", aluout4, 0);
    chk("midrst_in_ready", in_ready4, 1);
    @(posedge clk); #1 rst_n = 1;
    t4(1, 32'h77, 0, 0);
    chk("after_rst_head", aluout4, 32'h77);
    t4(0, 0, 1, 0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
